// File: rtl/sbox_bank_arbiter_if.sv
// Bundle of the request/response and bank-side signals of sbox_bank_arbiter.
// master: arbiter side (drives done/results, bank launch, status).
// slave: environment side (requesters, randomness source and S-box bank).
interface sbox_bank_arbiter_if #(
    parameter int ELEM_W = 8,
    parameter int R_W    = 8
);
    logic                   a_req;
    logic [16*ELEM_W-1:0]   a_in;
    logic                   a_done;
    logic [16*ELEM_W-1:0]   a_out;
    logic                   k_req;
    logic [4*ELEM_W-1:0]    k_in;
    logic                   k_done;
    logic [4*ELEM_W-1:0]    k_out;
    logic [7*R_W-1:0]       r_in;
    logic                   bank_start;
    logic [4*ELEM_W-1:0]    bank_in;
    logic [7*R_W-1:0]       bank_r;
    logic                   bank_drdy;
    logic [4*ELEM_W-1:0]    bank_out;
    logic                   busy;
    logic                   err;

    modport master (
        input  a_req, a_in, k_req, k_in, r_in, bank_drdy, bank_out,
        output a_done, a_out, k_done, k_out, bank_start, bank_in, bank_r, busy, err
    );

    modport slave (
        output a_req, a_in, k_req, k_in, r_in, bank_drdy, bank_out,
        input  a_done, a_out, k_done, k_out, bank_start, bank_in, bank_r, busy, err
    );
endinterface

// File: rtl/sbox_bank_arbiter.sv
// Time-shares one 4-lane S-box bank between the state path (16 elements, 4 passes)
// and the key schedule (4 elements, 1 pass); round-robin grant, non-preemptive.
// Latency: grant edge -> bank_start next cycle; each pass = bank latency + 1; done 1-cycle pulse.
// Backpressure: requests are levels held until done; WAIT stalls until bank_drdy.
// Ports: clk, rst (sync, active-high); io (master modport) carries requests,
// results, done pulses, bank launch/operands/randomness, busy and err.
// Optional watchdog: define SBOX_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles.
module sbox_bank_arbiter #(
    parameter int ELEM_W  = 8,
    parameter int R_W     = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    sbox_bank_arbiter_if.master io
);
    localparam int LANE_W = 4 * ELEM_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic                 grant_k;   // 1: current job belongs to the key path
    logic                 last_k;    // 1: key path was served last
    logic [1:0]           pass;
    logic [16*ELEM_W-1:0] snap;      // key jobs occupy the low 4 elements only
    logic [7*R_W-1:0]     rsave;
    logic [16*ELEM_W-1:0] a_res;
    logic [LANE_W-1:0]    k_res;

    logic                 pick_k;
    logic [1:0]           last_pass;
    logic [7*R_W-1:0]     r_rot;
    logic                 wd_fire;

    // On a tie the requester not served last wins.
    assign pick_k    = (io.a_req && io.k_req) ? !last_k : io.k_req;
    assign last_pass = grant_k ? 2'd0 : 2'd3;

    // new[j] = old[(j+4) mod 7]: elements 4..6 drop to 0..2, elements 0..3 move up to 3..6.
    assign r_rot = {rsave[4*R_W-1:0], rsave[7*R_W-1:4*R_W]};

`ifdef SBOX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // wd_cnt equals the number of WAIT cycles already elapsed in this pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT && wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A result arriving in the final cycle still completes the pass.
    assign wd_fire = (state == WAIT) && !io.bank_drdy && (wd_cnt == WD_W'(TIMEOUT));
    assign io.err  = wd_fire;
`else
    assign wd_fire = 1'b0;
    assign io.err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_k <= 1'b0;
            last_k  <= 1'b1;
            pass    <= 2'd0;
            snap    <= '0;
            rsave   <= '0;
            a_res   <= '0;
            k_res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.a_req || io.k_req) begin
                        grant_k <= pick_k;
                        snap    <= pick_k ? {{(12*ELEM_W){1'b0}}, io.k_in} : io.a_in;
                        rsave   <= io.r_in;
                        pass    <= 2'd0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (io.bank_drdy) begin
                        if (grant_k) begin
                            k_res <= io.bank_out;
                        end else begin
                            a_res[pass*LANE_W +: LANE_W] <= io.bank_out;
                        end
                        if (pass == last_pass) begin
                            state <= DONE;
                        end else begin
                            pass  <= pass + 2'd1;
                            rsave <= r_rot;
                            state <= ISSUE;
                        end
                    end else if (wd_fire) begin
                        // Aborted job still counts as served for fairness.
                        last_k <= grant_k;
                        state  <= IDLE;
                    end
                end
                DONE: begin
                    last_k <= grant_k;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.bank_start = (state == ISSUE);
    assign io.bank_in    = snap[pass*LANE_W +: LANE_W];
    assign io.bank_r     = rsave;
    assign io.a_done     = (state == DONE) && !grant_k;
    assign io.k_done     = (state == DONE) && grant_k;
    assign io.a_out      = a_res;
    assign io.k_out      = k_res;
    assign io.busy       = (state != IDLE);
endmodule

// File: tb/tb_sbox_bank_arbiter.sv
// Directed bench for sbox_bank_arbiter: behavioural bank with programmable latency,
// event logs indexed by cycle number, immediate-assertion comparisons.
// Inputs and the bank model change on the falling edge; outputs are sampled there too.
module tb_sbox_bank_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_bank_arbiter_if #(.ELEM_W(8), .R_W(8)) ifc ();

    sbox_bank_arbiter #(.ELEM_W(8), .R_W(8), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    // Bank model: results appear lat cycles after bank_start, each lane = operand + 1.
    int          lat = 3;
    bit          bm_never = 1'b0;
    bit          bm_flush = 1'b0;
    int          bm_left = 0;
    logic [31:0] bm_op;

    always @(negedge clk) begin
        ifc.bank_drdy = 1'b0;
        if (bm_flush) bm_left = 0;
        if (bm_left > 0) begin
            bm_left--;
            if (bm_left == 0 && !bm_never) begin
                ifc.bank_drdy = 1'b1;
                for (int i = 0; i < 4; i++) ifc.bank_out[i*8 +: 8] = bm_op[i*8 +: 8] + 8'd1;
            end
        end
        if (ifc.bank_start) begin
            bm_op   = ifc.bank_in;
            bm_left = lat;
        end
    end

    // Event monitor.
    int          starts[$];
    int          adone[$];
    int          kdone[$];
    int          errs[$];
    logic [55:0] rlog[$];

    always @(negedge clk) begin
        if (ifc.bank_start) begin
            starts.push_back(cyc);
            rlog.push_back(ifc.bank_r);
        end
        if (ifc.a_done) adone.push_back(cyc);
        if (ifc.k_done) kdone.push_back(cyc);
        if (ifc.err)    errs.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a done pulse; drop that request on its done cycle.
    task automatic wait_done(input bit want_k, output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (want_k ? ifc.k_done : ifc.a_done) begin
                c = cyc;
                if (want_k) ifc.k_req = 1'b0;
                else        ifc.a_req = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int             t;
        int             c;
        logic [127:0]   ea;
        logic [55:0]    rexp [4];

        rst        = 1'b1;
        ifc.a_req  = 1'b0;
        ifc.k_req  = 1'b0;
        ifc.a_in   = '0;
        ifc.k_in   = '0;
        ifc.r_in   = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_busy",  ifc.busy, 0);
        chk("rst_start", ifc.bank_start, 0);
        chk("rst_done",  {ifc.a_done, ifc.k_done}, 0);
        chk("rst_aout",  ifc.a_out, 0);
        chk("rst_kout",  ifc.k_out, 0);
        chk("rst_bankr", ifc.bank_r, 0);
        chk("rst_err",   ifc.err, 0);
        rst = 1'b0;

        // ---- lone A job, L=3, rotation of randomness ----
        @(negedge clk);
        lat = 3;
        for (int e = 0; e < 16; e++) ifc.a_in[e*8 +: 8] = 8'h10 + 8'(e);
        ifc.r_in = 56'h06050403020100;
        starts.delete(); rlog.delete(); adone.delete();
        ifc.a_req = 1'b1;
        t = cyc;
        @(negedge clk);
        chk("a_busy", ifc.busy, 1);
        ifc.a_in = '0;                 // operands and randomness may change after grant
        ifc.r_in = '1;
        wait_done(1'b0, c);
        chk("a_done_cyc", c, t + 17);
        chk("a_nstarts", starts.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("a_start%0d", i), starts[i], t + 1 + 4*i);
        rexp[0] = 56'h06050403020100;
        rexp[1] = 56'h03020100060504;
        rexp[2] = 56'h00060504030201;
        rexp[3] = 56'h04030201000605;
        for (int i = 0; i < 4; i++) chk($sformatf("a_bankr%0d", i), rlog[i], rexp[i]);
        for (int e = 0; e < 16; e++) ea[e*8 +: 8] = 8'h11 + 8'(e);
        chk("a_out", ifc.a_out, ea);
        @(negedge clk);
        chk("a_idle_busy", ifc.busy, 0);
        chk("a_single_done", adone.size(), 1);

        // ---- lone K job, L=1 ----
        lat = 1;
        ifc.k_in = 32'hA3A2A1A0;
        starts.delete(); kdone.delete();
        ifc.k_req = 1'b1;
        t = cyc;
        wait_done(1'b1, c);
        chk("k_done_cyc", c, t + 3);
        chk("k_nstarts", starts.size(), 1);
        chk("k_start0", starts[0], t + 1);
        chk("k_out", ifc.k_out, 32'hA4A3A2A1);
        chk("k_aout_hold", ifc.a_out, ea);

        // ---- simultaneous requests after reset: A then K ----
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("pair_rst_aout", ifc.a_out, 0);
        @(negedge clk);
        lat = 3;
        for (int e = 0; e < 16; e++) ifc.a_in[e*8 +: 8] = 8'h40 + 8'(e);
        ifc.k_in = 32'h03020100;
        starts.delete(); adone.delete(); kdone.delete();
        ifc.a_req = 1'b1;
        ifc.k_req = 1'b1;
        t = cyc;
        wait_done(1'b0, c);
        chk("p1_a_done_cyc", c, t + 17);
        chk("p1_k_not_yet", kdone.size(), 0);
        wait_done(1'b1, c);
        chk("p1_k_done_cyc", c, t + 23);
        chk("p1_k_start", starts[4], t + 19);
        chk("p1_k_out", ifc.k_out, 32'h04030201);

        // ---- lone A, L=1 (A now served last) ----
        @(negedge clk);
        lat = 1;
        adone.delete(); kdone.delete();
        ifc.a_req = 1'b1;
        t = cyc;
        wait_done(1'b0, c);
        chk("a2_done_cyc", c, t + 9);

        // ---- second simultaneous pair: K then A ----
        @(negedge clk);
        adone.delete(); kdone.delete();
        ifc.k_in  = 32'h11223344;
        ifc.a_req = 1'b1;
        ifc.k_req = 1'b1;
        t = cyc;
        wait_done(1'b1, c);
        chk("p2_k_done_cyc", c, t + 3);
        chk("p2_a_not_yet", adone.size(), 0);
        chk("p2_k_out", ifc.k_out, 32'h12233445);
        wait_done(1'b0, c);
        chk("p2_a_done_cyc", c, t + 13);

        // ---- reset during pass 2 of an A job ----
        @(negedge clk);
        lat = 3;
        starts.delete(); adone.delete();
        ifc.a_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (starts.size() >= 3) break;
        end
        chk("mid_pass2_reached", starts.size(), 3);
        @(negedge clk);
        rst       = 1'b1;
        ifc.a_req = 1'b0;
        bm_flush  = 1'b1;
        @(negedge clk);
        chk("mid_busy",  ifc.busy, 0);
        chk("mid_done",  {ifc.a_done, ifc.k_done}, 0);
        chk("mid_aout",  ifc.a_out, 0);
        chk("mid_bankin", {ifc.bank_start, ifc.bank_in, ifc.bank_r}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_no_adone", adone.size(), 0);
        bm_flush = 1'b0;
        lat = 2;
        ifc.k_in = 32'h7F7E7D7C;
        @(negedge clk);
        ifc.k_req = 1'b1;
        t = cyc;
        wait_done(1'b1, c);
        chk("mid_k_done_cyc", c, t + 4);
        chk("mid_k_out", ifc.k_out, 32'h807F7E7D);
        chk("mid_no_adone2", adone.size(), 0);

`ifdef SBOX_ARB_TIMEOUT_EN
        // ---- watchdog: bank never answers ----
        @(negedge clk);
        bm_never = 1'b1;
        adone.delete(); errs.delete();
        ifc.a_req = 1'b1;
        t = cyc;
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.err) begin
                c = cyc;
                ifc.a_req = 1'b0;
                break;
            end
        end
        ifc.a_req = 1'b0;
        chk("wd_err_cyc", c, t + 10);
        @(negedge clk);
        chk("wd_busy", ifc.busy, 0);
        chk("wd_err_pulse", ifc.err, 0);
        repeat (5) @(negedge clk);
        chk("wd_no_done", adone.size(), 0);
        chk("wd_single_err", errs.size(), 1);
        bm_never = 1'b0;
`else
        chk("no_err_ever", errs.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sbox_bank_arbiter.md
# sbox_bank_arbiter

Scheduler that time-shares one bank of four CLM S-boxes between two requesters: the state path (SubBytes, 16 elements, 4 passes) and the key schedule (SubWord, 4 elements, 1 pass). It snapshots the granted requester's operands and randomness vector, then sequences the bank pass by pass. It shifts the randomness between passes and returns results with a one-cycle done pulse. It sits between the round controller / key expansion and the S-box bank.

## Interface
- ELEM_W, 8, width of one transformed byte element
- R_W, 8, width of one randomness element (NR = 7 elements, fixed)
- TIMEOUT, 64, watchdog limit in cycles; used only with the configuration macro
- clk  in  1  clock
- rst  in  1  reset
- Reset: synchronous, active-high
- a_req  in  1  state-path request (level)
- a_in  in  16*ELEM_W  state operands; element e at bits [e*ELEM_W +: ELEM_W]
- a_done  out  1  one-cycle pulse: a_out valid
- a_out  out  16*ELEM_W  state results, same packing
- k_req  in  1  key-path request (level)
- k_in  in  4*ELEM_W  key-word operands
- k_done  out  1  one-cycle pulse: k_out valid
- k_out  out  4*ELEM_W  key-word results
- r_in  in  7*R_W  fresh randomness vector, element j at [j*R_W +: R_W]
- bank_start  out  1  one-cycle pulse launching a bank pass
- bank_in  out  4*ELEM_W  lane operands for the pass
- bank_r  out  7*R_W  randomness vector presented to the bank
- bank_drdy  in  1  bank results valid
- bank_out  in  4*ELEM_W  lane results
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle watchdog-abort pulse; constant 0 without the macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if any request is high at a clock edge, the arbiter grants, snapshots operands and r_in, clears pass to 0, and moves to ISSUE.
- **Arbitration when both requests are high:** grant the requester not served last (round-robin via a last_k flag; reset value 1, so A wins first). With one request high, grant that request. Jobs are non-preemptive.
- **ISSUE (1 cycle):** bank_start=1. bank_in lane i = snapshot element 4*pass+i. Next state is WAIT.
- **WAIT:** on bank_drdy=1, write bank_out lane i into result element 4*pass+i of a_out or k_out.
  - If pass is the last pass (3 for A, 0 for K), go to DONE.
  - Otherwise, increment pass, rotate the saved randomness left by 4 elements (new[j] = old[(j+4) mod 7]), and go to ISSUE.
- **DONE (1 cycle):** pulse the granted requester's done output. Update last_k. Next state is IDLE.
  - Requests are ignored in DONE. A requester still holding req in the following IDLE cycle is granted again, so requesters drop req on their done cycle.
- bank_r always equals the saved randomness register.
- bank_drdy outside WAIT is ignored.
- a_out/k_out hold their values until the same requester's next job writes them. Operands may change after the grant edge.
- **Reset (any state, mid-job included):** state goes to IDLE. All outputs, the snapshot registers, saved randomness, pass and last_k are reset. Outputs reset to 0, except last_k, which resets to 1. No done is issued for the aborted job.

## Timing
- Bank latency L is the number of cycles from bank_start to bank_drdy (L ≥ 1). One pass takes L+1 cycles.
- If a request is high at edge t (arbiter in IDLE), bank_start is asserted in cycle t+1.
- A job: a_done is asserted in cycle t+1+4(L+1). With L=3, that is t+17.
- K job: k_done is asserted in cycle t+1+(L+1). With L=3, that is t+5.
- Back-to-back jobs: the earliest next grant is at the edge ending the first IDLE cycle after DONE.
- Randomness: r_in is sampled only at the grant edge. A job passes 1..3 see the vector rotated by 4, 8 and 12 elements.

## Configuration
- SBOX_ARB_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT without bank_drdy, the FSM goes to IDLE and err pulses for one cycle. No done is issued.
  - Result slots from already-completed passes keep their new values; the remaining slots keep their old values. last_k is updated as if the job had completed.
- SBOX_ARB_TIMEOUT_EN undefined: no counter is built, err is tied to 0, and WAIT can last indefinitely.

## Test plan
- **Lone A job:** a_req=1, a_in elements e=0..15 set to 0x10+e, bank model L=3 with lane i returning in+1. Required: bank_start in cycles t+1, t+5, t+9, t+13; a_done at t+17; a_out element e = 0x11+e.
- **Lone K job:** k_in = {0xA0,0xA1,0xA2,0xA3}, L=1. Required: one bank_start; k_done at t+3; k_out = {0xA1..0xA4}.
- **Simultaneous requests after reset:** A is served first, then K is granted one IDLE cycle after a_done. A second simultaneous pair is served K then A.
- **Randomness rotation:** r_in elements j = j. Required: bank_r is 0..6 in pass 0, then 4,5,6,0,1,2,3 in pass 1, then 1,2,3,4,5,6,0 in pass 2.
- **Reset mid-job:** rst asserted during pass 2 of an A job. Required: the next cycle shows busy=0, all outputs 0, no a_done; a new K request then completes normally.
- **Watchdog (macro defined, TIMEOUT=8):** bank never asserts drdy. Required: err pulses 8 cycles after entering WAIT, busy=0 on the next cycle, no done.
